spram_arbiter: RTL and testbench

Arbiter that shares one single-port synchronous SRAM (one access per cycle, read data one cycle after a read) among `N_REQ` requesters, e.g. host register-bus access and baseband engine state/dump traffic. It sits directly in front of the SRAM instance. It grants at most one requester per cycle and drives that requester's command onto the SRAM port in the same cycle. It tags each read so that the returned data valid pulse reaches the originating requester. A per-requester lock lets one requester hold the RAM for back-to-back burst accesses.

---
 rtl/spram_arb_pkg.sv | 23 ++
 rtl/spram_arbiter_rr_pick.sv | 40 ++++
 rtl/spram_arbiter.sv | 115 +++++++++++
 tb/tb_spram_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_arb_pkg.sv
// ---------------------------------------------------------------------------
// spram_arb_pkg: shared limits and index-width helper for spram_arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spram_arb_pkg;

  localparam int SPRAM_ARB_MAX_REQ = 8;

  // Width of an index into a vector of `value` entries; never narrower than 1.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spram_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick: combinational one-hot picker, searching upward from `start` with wrap.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int N    = 3,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] start,
  output logic [N-1:0]    gnt
);

  localparam logic [IDXW:0] N_W = (IDXW+1)'(N);

  logic            found;
  logic [IDXW:0]   pos;
  logic [IDXW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, start} + (IDXW+1)'(k);
      if (pos >= N_W) pos = pos - N_W;
      idx = pos[IDXW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spram_arbiter.sv
// ---------------------------------------------------------------------------
// spram_arbiter: shares one single-port SRAM among N_REQ requesters, with read tagging and lock.
// Option: SPRAM_ARB_ROUND_ROBIN_EN selects round-robin (default: fixed priority). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            we,
  input  logic [N_REQ-1:0]            lock,
  input  logic [N_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic [DATA_WIDTH-1:0]       mem_rdata
);

  localparam int              IDXW     = clog2(N_REQ);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_REQ - 1);

  if (N_REQ < 2 || N_REQ > SPRAM_ARB_MAX_REQ) begin : g_bad_n_req
    $error("spram_arbiter: N_REQ out of range");
  end

  logic [IDXW-1:0]  last;
  logic [IDXW-1:0]  owner;
  logic             owner_vld;
  logic             lock_hit;
  logic [N_REQ-1:0] rd_tag;
  logic [N_REQ-1:0] pick_gnt;
  logic [IDXW-1:0]  start;
  logic [IDXW-1:0]  gnt_idx;

`ifdef SPRAM_ARB_ROUND_ROBIN_EN
  assign start = (last == LAST_IDX) ? '0 : last + 1'b1;
`else
  // Fixed priority: search always begins at index 0; last is kept but not consulted.
  logic unused_last;
  assign start       = '0;
  assign unused_last = ^last;
`endif

  rr_pick #(
    .N    (N_REQ),
    .IDXW (IDXW)
  ) u_pick (
    .req   (req),
    .start (start),
    .gnt   (pick_gnt)
  );

  // A lock owner that still requests overrides arbitration; once it drops req the
  // picker result is used in that very cycle.
  always_comb begin
    lock_hit = owner_vld & req[owner];
    gnt      = pick_gnt;
    if (lock_hit) begin
      gnt        = '0;
      gnt[owner] = 1'b1;
    end
  end

  always_comb begin
    gnt_idx   = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx   = gnt_idx | IDXW'(i);
        mem_we    = mem_we | we[i];
        mem_addr  = mem_addr | addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata = mem_wdata | wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign mem_en = |gnt;
  assign rvalid = rd_tag;
  assign rdata  = mem_rdata;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      last      <= LAST_IDX;
      owner     <= '0;
      owner_vld <= 1'b0;
      rd_tag    <= '0;
    end else begin
      rd_tag <= gnt & ~we;
      if (mem_en) begin
        last      <= gnt_idx;
        owner     <= gnt_idx;
        owner_vld <= lock[gnt_idx];
      end else begin
        owner_vld <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spram_arbiter: directed plus random checks of spram_arbiter against a reference model.
// Follows SPRAM_ARB_ROUND_ROBIN_EN to choose the expected arbitration policy. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spram_arbiter;

  localparam int N  = 3;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_b;
  logic [N-1:0]  req, we, lock, gnt, rvalid;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  spram_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .we(we), .lock(lock), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    logic [31:0] av;
    av = a;
    return 32'hC0DE_0000 ^ (av * 32'h0001_0003);
  endfunction

  // SRAM instance model: synchronous, one access per cycle, read data next cycle.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  logic          mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1<<AW); i++) sram[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_last, m_owner, m_g;
  logic [N-1:0]  m_rd;
  logic [DW-1:0] m_rdata;
  int            errors = 0;
  int            checks = 0;
  logic [N-1:0]  s_gnt, s_rvalid;
  logic [DW-1:0] s_rdata;
  logic [N-1:0]  seq [4];
  bit            hold [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick();
    if (m_owner >= 0 && req[m_owner]) return m_owner;
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (req[i]) return i;
    end
`else
    for (int i = 0; i < N; i++) if (req[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_last  = N - 1;
    m_owner = -1;
    m_rd    = '0;
  endtask

  task automatic drv(input int i, input bit r, input bit w, input bit l, input int a,
                     input logic [DW-1:0] d);
    req[i]  = r;
    we[i]   = w;
    lock[i] = l;
    addr[i*AW +: AW]  = AW'(a);
    wdata[i*DW +: DW] = d;
  endtask

  task automatic idle();
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
  endtask

  // Called at posedge+1 with inputs set; checks at the falling edge, then advances the model.
  task automatic step(input string tag);
    logic [N-1:0]  eg;
    logic [AW-1:0] ga;
    #4;
    m_g = model_pick();
    eg  = '0;
    if (m_g >= 0) eg[m_g] = 1'b1;
    s_gnt = gnt; s_rvalid = rvalid; s_rdata = rdata;
    chk({tag, ".gnt"}, 64'(gnt), 64'(eg));
    chk({tag, ".mem_en"}, 64'(mem_en), 64'(m_g >= 0));
    if (m_g >= 0) begin
      chk({tag, ".mem_we"}, 64'(mem_we), 64'(we[m_g]));
      chk({tag, ".mem_addr"}, 64'(mem_addr), 64'(addr[m_g*AW +: AW]));
      chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(wdata[m_g*DW +: DW]));
    end else begin
      chk({tag, ".mem_idle"}, {31'd0, mem_we, 22'd0, mem_addr}, 64'd0);
      chk({tag, ".mem_wdata0"}, 64'(mem_wdata), 64'd0);
    end
    chk({tag, ".rvalid"}, 64'(rvalid), 64'(m_rd));
    if (m_rd != '0) chk({tag, ".rdata"}, 64'(rdata), 64'(m_rdata));
    @(posedge clk);
    if (m_g >= 0) begin
      ga      = addr[m_g*AW +: AW];
      m_last  = m_g;
      m_owner = lock[m_g] ? m_g : -1;
      m_rd    = '0;
      if (we[m_g]) ref_mem[ga] = wdata[m_g*DW +: DW];
      else begin
        m_rd[m_g] = 1'b1;
        m_rdata   = ref_mem[ga];
      end
    end else begin
      m_owner = -1;
      m_rd    = '0;
    end
    #1;
  endtask

  initial begin
    rst_b = 1'b0;
    mem_init = 1'b1;
    idle();
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_word(i);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    chk("reset.gnt", 64'(gnt), 64'd0);
    chk("reset.rvalid", 64'(rvalid), 64'd0);
    chk("reset.mem", {31'd0, mem_en, 22'd0, mem_addr}, 64'd0);
    chk("reset.mem_we_wdata", {31'd0, mem_we, mem_wdata}, 64'd0);
    rst_b = 1'b1;

    // All three requesters read continuously
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
`else
    seq[0] = 3'b001; seq[1] = 3'b001; seq[2] = 3'b001; seq[3] = 3'b001;
`endif
    drv(0, 1, 0, 0, 'h100, '0);
    drv(1, 1, 0, 0, 'h200, '0);
    drv(2, 1, 0, 0, 'h300, '0);
    for (int k = 0; k < 4; k++) begin
      step("t1");
      chk("t1.seq", 64'(s_gnt), 64'(seq[k]));
    end
    idle();
    step("t1.drain");

    // Write by requester 1 then read-back by requester 2
    drv(1, 1, 1, 0, 'h010, 32'hA5A5_0001);
    step("t2.wr");
    idle();
    drv(2, 1, 0, 0, 'h010, '0);
    step("t2.rd");
    idle();
    step("t2.rv");
    chk("t2.rvalid", 64'(s_rvalid), 64'(3'b100));
    chk("t2.rdata", 64'(s_rdata), 64'(32'hA5A5_0001));

    // Locked burst by requester 2 while requester 0 keeps requesting
    drv(2, 1, 0, 1, 'h020, '0);
    step("t3.lock0");
    chk("t3.lockgnt", 64'(s_gnt), 64'(3'b100));
    drv(0, 1, 0, 0, 'h030, '0);
    for (int k = 1; k < 4; k++) begin
      drv(2, 1, 0, 1, 'h020 + k, '0);
      step("t3.burst");
      chk("t3.lockgnt", 64'(s_gnt), 64'(3'b100));
    end
    drv(2, 0, 0, 0, 0, '0);
    step("t3.release");
    chk("t3.release_gnt", 64'(s_gnt), 64'(3'b001));
    idle();
    step("t3.drain");

    // Writes only, request toggling every cycle
    for (int k = 0; k < 8; k++) begin
      idle();
      if (k % 2 == 0) drv($urandom_range(0, N-1), 1, 1, 0, $urandom_range(0, 15), $urandom);
      step("t4");
      chk("t4.no_rvalid", 64'(s_rvalid), 64'd0);
    end

    // Reset in the cycle after a granted read, with a lock held
    idle();
    drv(2, 1, 0, 1, 'h005, '0);
    step("t5.lock");
    drv(0, 1, 0, 0, 'h006, '0);
    step("t5.rd");
    rst_b = 1'b0;
    #1;
    chk("t5.rst_rvalid", 64'(rvalid), 64'd0);
    chk("t5.rst_gnt", 64'(gnt), 64'(3'b001));
    model_reset();
    idle();
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    drv(0, 1, 0, 0, 'h007, '0);
    drv(1, 1, 0, 0, 'h008, '0);
    drv(2, 1, 0, 0, 'h009, '0);
    step("t5.post");
    chk("t5.first_gnt", 64'(s_gnt), 64'(3'b001));
    idle();
    step("t5.drain");

    // Idle bus
    for (int k = 0; k < 10; k++) begin
      step("t6");
      chk("t6.idle", {s_gnt, s_rvalid}, 64'd0);
    end

    // Random traffic; each requester holds its command until granted
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          if ($urandom_range(0, 99) < 60) begin
            drv(i, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 30,
                $urandom_range(0, 15), $urandom);
            hold[i] = 1'b1;
          end else begin
            drv(i, 0, 0, 0, 0, '0);
          end
        end
      end
      step("t7");
      if (m_g >= 0) hold[m_g] = 1'b0;
    end
    idle();
    step("t7.drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
